// File: rtl/rc4_pkg.sv
// Shared RC4 engine definitions: FSM state codes, S-box geometry, drop length.
// Optional feature macro: RC4_DROP_EN (discard the first DROP_N keystream bytes).
package rc4_pkg;

    localparam int unsigned SBOX_DEPTH = 256;
    localparam int unsigned DROP_N     = 768;

`ifdef RC4_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef logic [7:0] byte_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_KSA  = 3'd2;
    localparam logic [2:0] ST_DROP = 3'd3;
    localparam logic [2:0] ST_GEN  = 3'd4;

    // Cycles from an accepted start to the first ks_valid.
    function automatic int unsigned first_valid_latency();
        return 2 * SBOX_DEPTH + 1 + (DROP_EN ? DROP_N : 0);
    endfunction

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation store: 256x8 registers, three async reads, two writes.
// When both writes hit one address port b lands last; a swap with itself
// writes the same value twice, so it is a no-op either way.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  byte_t rd_addr_a,
    input  byte_t rd_addr_b,
    input  byte_t rd_addr_t,
    output byte_t rd_data_a,
    output byte_t rd_data_b,
    output byte_t rd_data_t,
    input  logic  we_a,
    input  byte_t wr_addr_a,
    input  byte_t wr_data_a,
    input  logic  we_b,
    input  byte_t wr_addr_b,
    input  byte_t wr_data_b
);

    byte_t mem [SBOX_DEPTH];

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];
    assign rd_data_t = mem[rd_addr_t];

    // Storage update; contents are rebuilt by INIT so no reset is needed.
    always_ff @(posedge clk) begin
        if (we_a) mem[wr_addr_a] <= wr_data_a;
        if (we_b) mem[wr_addr_b] <= wr_data_b;
    end

endmodule

// File: rtl/rc4_stream_core.sv
// RC4 keystream engine: key RAM, INIT/KSA/GEN sequencing and valid/ready output.
// Optional macro RC4_DROP_EN inserts a DROP phase discarding DROP_N bytes.
module rc4_stream_core
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_MAX_LEN = 16,
    parameter int unsigned KLW         = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_we,
    input  logic [KLW-2:0] key_addr,
    input  byte_t          key_data,
    input  logic [KLW-1:0] key_len,
    input  logic           start,
    output logic           busy,
    output logic           data_rready,
    output logic           err,
    output byte_t          ks_data,
    output logic           ks_valid,
    input  logic           ks_ready
);

    localparam int unsigned KAW       = KLW - 1;
    localparam int unsigned KEY_DEPTH = 1 << KAW;
`ifdef RC4_DROP_EN
    localparam int unsigned DCW = $clog2(DROP_N);
`endif

    logic [2:0]     state, state_nxt;
    byte_t          cnt, cnt_nxt;
    byte_t          i, i_nxt, j, j_nxt;
    logic [KAW-1:0] kidx, kidx_nxt;
    logic [KLW-1:0] klen, klen_nxt;
    byte_t          ks_data_nxt;
    logic           ks_valid_nxt, busy_nxt, rready_nxt, err_nxt;
`ifdef RC4_DROP_EN
    logic [DCW-1:0] drop_cnt, drop_cnt_nxt;
`endif

    byte_t key_mem [KEY_DEPTH];

    byte_t i_inc, rd_addr_a, key_byte, j_new, t_idx, ks_next;
    byte_t s_a, s_b, s_t;
    logic  we_a, we_b;
    byte_t wr_addr_a, wr_data_a, wr_addr_b, wr_data_b;
    logic  len_ok, can_start, accept, reject, gen_step;

    // Shared datapath: KSA reads S[cnt], PRGA reads S[i+1]; then S[j'] and S[t].
    assign i_inc     = i + 8'd1;
    assign rd_addr_a = (state == ST_KSA) ? cnt : i_inc;
    assign key_byte  = (state == ST_KSA) ? key_mem[kidx] : 8'd0;
    assign j_new     = j + s_a + key_byte;
    assign t_idx     = s_a + s_b;
    assign ks_next   = (t_idx == rd_addr_a) ? s_b : ((t_idx == j_new) ? s_a : s_t);

    assign len_ok    = (key_len != '0) && (key_len <= KLW'(KEY_MAX_LEN));
    assign can_start = (state == ST_IDLE) || (state == ST_GEN);
    assign accept    = can_start && start && len_ok;
    assign reject    = can_start && start && !len_ok;
    assign gen_step  = (state == ST_GEN) && (!ks_valid || ks_ready);

    rc4_sbox u_sbox (
        .clk       (clk),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (j_new),
        .rd_addr_t (t_idx),
        .rd_data_a (s_a),
        .rd_data_b (s_b),
        .rd_data_t (s_t),
        .we_a      (we_a),
        .wr_addr_a (wr_addr_a),
        .wr_data_a (wr_data_a),
        .we_b      (we_b),
        .wr_addr_b (wr_addr_b),
        .wr_data_b (wr_data_b)
    );

    // Key bytes are writable only while idle.
    always_ff @(posedge clk) begin
        if (key_we && (state == ST_IDLE)) key_mem[key_addr] <= key_data;
    end

    // Next-state, counters, S-box write control and output next values.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        i_nxt        = i;
        j_nxt        = j;
        kidx_nxt     = kidx;
        klen_nxt     = klen;
        ks_data_nxt  = ks_data;
        ks_valid_nxt = ks_valid;
        err_nxt      = reject;
        busy_nxt     = 1'b0;
        rready_nxt   = 1'b0;
        we_a         = 1'b0;
        wr_addr_a    = '0;
        wr_data_a    = '0;
        we_b         = 1'b0;
        wr_addr_b    = '0;
        wr_data_b    = '0;
`ifdef RC4_DROP_EN
        drop_cnt_nxt = drop_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                    klen_nxt  = key_len;
                end
            end
            ST_INIT: begin
                we_a      = 1'b1;
                wr_addr_a = cnt;
                wr_data_a = cnt;
                cnt_nxt   = cnt + 8'd1;
                if (cnt == 8'hFF) begin
                    state_nxt = ST_KSA;
                    j_nxt     = '0;
                    kidx_nxt  = '0;
                end
            end
            ST_KSA: begin
                we_a      = 1'b1;
                wr_addr_a = cnt;
                wr_data_a = s_b;
                we_b      = 1'b1;
                wr_addr_b = j_new;
                wr_data_b = s_a;
                j_nxt     = j_new;
                cnt_nxt   = cnt + 8'd1;
                kidx_nxt  = (KLW'(kidx) == klen - KLW'(1)) ? '0 : kidx + KAW'(1);
                if (cnt == 8'hFF) begin
                    i_nxt = '0;
                    j_nxt = '0;
`ifdef RC4_DROP_EN
                    state_nxt    = ST_DROP;
                    drop_cnt_nxt = '0;
`else
                    state_nxt = ST_GEN;
`endif
                end
            end
`ifdef RC4_DROP_EN
            ST_DROP: begin
                we_a         = 1'b1;
                wr_addr_a    = i_inc;
                wr_data_a    = s_b;
                we_b         = 1'b1;
                wr_addr_b    = j_new;
                wr_data_b    = s_a;
                i_nxt        = i_inc;
                j_nxt        = j_new;
                drop_cnt_nxt = drop_cnt + DCW'(1);
                if (drop_cnt == DCW'(DROP_N - 1)) state_nxt = ST_GEN;
            end
`endif
            ST_GEN: begin
                if (accept) begin
                    state_nxt    = ST_INIT;
                    cnt_nxt      = '0;
                    klen_nxt     = key_len;
                    ks_valid_nxt = 1'b0;
                end else if (gen_step) begin
                    we_a         = 1'b1;
                    wr_addr_a    = i_inc;
                    wr_data_a    = s_b;
                    we_b         = 1'b1;
                    wr_addr_b    = j_new;
                    wr_data_b    = s_a;
                    i_nxt        = i_inc;
                    j_nxt        = j_new;
                    ks_data_nxt  = ks_next;
                    ks_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt   = (state_nxt == ST_INIT) || (state_nxt == ST_KSA) || (state_nxt == ST_DROP);
        rready_nxt = (state_nxt == ST_GEN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            i           <= '0;
            j           <= '0;
            kidx        <= '0;
            klen        <= '0;
            ks_data     <= '0;
            ks_valid    <= 1'b0;
            busy        <= 1'b0;
            data_rready <= 1'b0;
            err         <= 1'b0;
`ifdef RC4_DROP_EN
            drop_cnt    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            i           <= i_nxt;
            j           <= j_nxt;
            kidx        <= kidx_nxt;
            klen        <= klen_nxt;
            ks_data     <= ks_data_nxt;
            ks_valid    <= ks_valid_nxt;
            busy        <= busy_nxt;
            data_rready <= rready_nxt;
            err         <= err_nxt;
`ifdef RC4_DROP_EN
            drop_cnt    <= drop_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rc4_stream_core.sv
// Scoreboard bench for rc4_stream_core: a plain-array RC4 model fills an expected
// queue at each start; a forked monitor pops and compares on every handshake.
module tb_rc4_stream_core;

    localparam int unsigned KLW = 5;
`ifdef RC4_DROP_EN
    localparam int DROP = 768;
`else
    localparam int DROP = 0;
`endif

    logic           clk, rst, key_we, start, ks_ready;
    logic [KLW-2:0] key_addr;
    logic [7:0]     key_data, ks_data;
    logic [KLW-1:0] key_len;
    logic           busy, data_rready, err, ks_valid;

    int         n_tests, n_fail;
    logic [7:0] exp_q [$];
    logic [7:0] kmem [16];
    logic [7:0] key_gold [10];
    logic [7:0] wiki_gold [5];

    rc4_stream_core #(.KEY_MAX_LEN(16), .KLW(KLW)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_we      (key_we),
        .key_addr    (key_addr),
        .key_data    (key_data),
        .key_len     (key_len),
        .start       (start),
        .busy        (busy),
        .data_rready (data_rready),
        .err         (err),
        .ks_data     (ks_data),
        .ks_valid    (ks_valid),
        .ks_ready    (ks_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake monitor: pops one expected byte per accepted transfer, checks hold on stall.
    task automatic monitor();
        logic       hv;
        logic [7:0] hd, e;
        hv = 1'b0;
        hd = '0;
        forever begin
            @(negedge clk);
            if (rst && ks_valid) begin
                if (hv) check("stall_hold", 32'(ks_data), 32'(hd));
                if (ks_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h required none", ks_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("ks_byte", 32'(ks_data), 32'(e));
                    end
                    hv = 1'b0;
                end else begin
                    hv = 1'b1;
                    hd = ks_data;
                end
            end else begin
                hv = 1'b0;
            end
        end
    endtask

    // Reference RC4 (textbook form) over kmem[0..len-1], skipping DROP bytes.
    task automatic push_model(input int len, input int n, input int golden);
        int s [256];
        int a, b, tmp;
        b = 0;
        for (int k = 0; k < 256; k++) s[k] = k;
        for (int k = 0; k < 256; k++) begin
            b = (b + s[k] + int'(kmem[k % len])) % 256;
            tmp = s[k]; s[k] = s[b]; s[b] = tmp;
        end
        a = 0;
        b = 0;
        for (int k = 0; k < DROP + n; k++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
            if (k >= DROP) exp_q.push_back(8'(s[(s[a] + s[b]) % 256]));
        end
        if (DROP == 0 && golden == 1) for (int k = 0; k < 10; k++) exp_q[k] = key_gold[k];
        if (DROP == 0 && golden == 2) for (int k = 0; k < 5; k++) exp_q[k] = wiki_gold[k];
    endtask

    task automatic load_key(input int len, input bit skip0);
        for (int k = (skip0 ? 1 : 0); k < len; k++) begin
            key_we   = 1'b1;
            key_addr = (KLW-1)'(k);
            key_data = kmem[k];
            tick();
        end
        key_we = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        start    = 1'b0;
        key_we   = 1'b0;
        ks_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic run(input int len, input int n, input bit rnd, input bit wr0,
                       input bit poke, input int golden);
        int cyc;
        bit was_gen;
        exp_q.delete();
        push_model(len, n, golden);
        was_gen = data_rready;
        start   = 1'b1;
        key_len = KLW'(len);
        if (wr0) begin
            key_we   = 1'b1;
            key_addr = '0;
            key_data = kmem[0];
        end
        tick();
        start  = 1'b0;
        key_we = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        if (was_gen) check("valid_drop_on_restart", 32'(ks_valid), 32'd0);
        cyc = 0;
        while (!ks_valid && cyc < 3000) begin
            if (poke && cyc == 50) begin
                start    = 1'b1;
                key_we   = 1'b1;
                key_addr = '0;
                key_data = ~kmem[0];
            end else begin
                start  = 1'b0;
                key_we = 1'b0;
            end
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        start  = 1'b0;
        key_we = 1'b0;
        check("start_latency", 32'(cyc), 32'(513 + DROP));
        check("rready_in_gen", 32'(data_rready), 32'd1);
        check("busy_in_gen", 32'(busy), 32'd0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 4 * n + 100) begin
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        ks_ready = 1'b0;
        check("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reject_check(input int len, input bit in_gen);
        start   = 1'b1;
        key_len = KLW'(len);
        tick();
        start = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("rready_kept", 32'(data_rready), 32'(in_gen));
        check("busy_unchanged", 32'(busy), 32'd0);
        tick();
        check("err_clear", 32'(err), 32'd0);
        check("state_kept", 32'(data_rready), 32'(in_gen));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        key_we    = 1'b0;
        key_addr  = '0;
        key_data  = '0;
        key_len   = '0;
        ks_ready  = 1'b0;
        key_gold  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        wiki_gold = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};
        for (int k = 0; k < 16; k++) kmem[k] = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rready", 32'(data_rready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(ks_valid), 32'd0);
        check("rst_data", 32'(ks_data), 32'd0);
        rst = 1'b1;
        tick();

        // "Key": byte 0 written in the same cycle as start.
        kmem[0] = 8'h4B; kmem[1] = 8'h65; kmem[2] = 8'h79;
        load_key(3, 1'b1);
        run(3, 16, 1'b0, 1'b1, 1'b0, 1);
        reject_check(0, 1'b1);
        // Restart from GEN with random stalls; start and key write while busy are ignored.
        run(3, 40, 1'b1, 1'b0, 1'b1, 1);

        do_reset();
        reject_check(0, 1'b0);
        reject_check(17, 1'b0);

        kmem[0] = 8'h57; kmem[1] = 8'h69; kmem[2] = 8'h6B; kmem[3] = 8'h69;
        load_key(4, 1'b0);
        run(4, 8, 1'b0, 1'b0, 1'b0, 2);

        // Async reset in the middle of KSA.
        start   = 1'b1;
        key_len = KLW'(4);
        tick();
        start = 1'b0;
        repeat (356) tick();
        check("busy_mid_ksa", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rready", 32'(data_rready), 32'd0);
        check("arst_valid", 32'(ks_valid), 32'd0);
        check("arst_data", 32'(ks_data), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        kmem[0] = 8'h4B; kmem[1] = 8'h65; kmem[2] = 8'h79;
        load_key(3, 1'b0);
        run(3, 12, 1'b0, 1'b0, 1'b0, 1);

        // Maximum key length, then restart from GEN with a shorter prefix.
        do_reset();
        for (int k = 0; k < 16; k++) kmem[k] = 8'(k);
        load_key(16, 1'b0);
        run(16, 30, 1'b1, 1'b0, 1'b0, 0);
        run(7, 20, 1'b1, 1'b0, 1'b0, 0);

        for (int r = 0; r < 3; r++) begin
            int len;
            do_reset();
            len = int'($urandom_range(1, 16));
            for (int k = 0; k < 16; k++) kmem[k] = 8'($urandom);
            load_key(len, 1'b0);
            run(len, 25, 1'b1, 1'b0, 1'b0, 0);
        end

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
